// File: rtl/board_mem_arbiter_if.sv
// Request/grant/response bundle between the board draw path, the game logic,
// the cell RAM and board_mem_arbiter.
interface board_mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 4
);
  logic              draw_req;
  logic [ADDR_W-1:0] draw_addr;
  logic              draw_gnt;
  logic [DATA_W-1:0] draw_rdata;
  logic              draw_rvalid;

  logic              lg_req;
  logic              lg_we;
  logic [ADDR_W-1:0] lg_addr;
  logic [DATA_W-1:0] lg_wdata;
  logic              lg_gnt;
  logic [DATA_W-1:0] lg_rdata;
  logic              lg_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  draw_req, draw_addr, lg_req, lg_we, lg_addr, lg_wdata, mem_rdata,
    output draw_gnt, draw_rdata, draw_rvalid, lg_gnt, lg_rdata, lg_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters and RAM side.
  modport master (
    output draw_req, draw_addr, lg_req, lg_we, lg_addr, lg_wdata, mem_rdata,
    input  draw_gnt, draw_rdata, draw_rvalid, lg_gnt, lg_rdata, lg_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// Video-phase arbiter for the single-port board cell RAM (draw vs game logic).
// Define BOARD_ARB_STARVE_EN to bound the logic requester's wait to MAX_WAIT+1 cycles.
module board_mem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 4,
  parameter int MAX_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vblnk,
  board_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_VIDEO = 2'd0,
    S_BLANK = 2'd1
`ifdef BOARD_ARB_STARVE_EN
    , S_FORCE = 2'd2
`endif
  } state_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  localparam logic OWN_DRAW = 1'b0;
  localparam logic OWN_LG   = 1'b1;

  if (MAX_WAIT < 1) begin : g_bad_cfg
    $error("board_mem_arbiter: MAX_WAIT must be at least 1");
  end

  state_t            state;
  state_t            state_nxt;
  logic              vblnk_q;
  logic              draw_gnt;
  logic              lg_gnt;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  tag_t              tag_s1;
  tag_t              tag_s2;

  logic              draw_rvalid;
  logic [DATA_W-1:0] draw_rdata;
  logic              lg_rvalid;
  logic [DATA_W-1:0] lg_rdata;

`ifdef BOARD_ARB_STARVE_EN
  localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  logic [WAIT_W-1:0] wait_cnt;
`endif

  // Grants are masked during reset so every output reads 0 while rst is high.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a grant unassigned (no latch).
    draw_gnt = 1'b0;
    lg_gnt   = 1'b0;
    if (!rst) begin
      case (state)
        S_VIDEO: begin
          draw_gnt = bus.draw_req;
          lg_gnt   = bus.lg_req & ~bus.draw_req;
        end
        S_BLANK: begin
          lg_gnt   = bus.lg_req;
          draw_gnt = bus.draw_req & ~bus.lg_req;
        end
`ifdef BOARD_ARB_STARVE_EN
        S_FORCE: begin
          lg_gnt   = bus.lg_req;
        end
`endif
        default: begin
          draw_gnt = 1'b0;
          lg_gnt   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_VIDEO: begin
        if (vblnk_q) begin
          state_nxt = S_BLANK;
        end
`ifdef BOARD_ARB_STARVE_EN
        else if (wait_cnt == WAIT_MAX) begin
          state_nxt = S_FORCE;
        end
`endif
      end
      S_BLANK: begin
        if (!vblnk_q) state_nxt = S_VIDEO;
      end
`ifdef BOARD_ARB_STARVE_EN
      S_FORCE: state_nxt = vblnk_q ? S_BLANK : S_VIDEO;
`endif
      default: state_nxt = S_VIDEO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_VIDEO;
      vblnk_q     <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      tag_s1      <= '0;
      tag_s2      <= '0;
      draw_rvalid <= 1'b0;
      draw_rdata  <= '0;
      lg_rvalid   <= 1'b0;
      lg_rdata    <= '0;
`ifdef BOARD_ARB_STARVE_EN
      wait_cnt    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before it.
      state   <= state_nxt;
      vblnk_q <= vblnk;

      mem_en <= draw_gnt | lg_gnt;
      mem_we <= lg_gnt & bus.lg_we;
      if (draw_gnt) begin
        mem_addr <= bus.draw_addr;
      end else if (lg_gnt) begin
        mem_addr  <= bus.lg_addr;
        mem_wdata <= bus.lg_wdata;
      end

      // Only reads are tagged valid, so writes never produce a response.
      tag_s1.valid <= draw_gnt | (lg_gnt & ~bus.lg_we);
      tag_s1.owner <= lg_gnt ? OWN_LG : OWN_DRAW;
      tag_s2       <= tag_s1;

      draw_rvalid <= tag_s2.valid & (tag_s2.owner == OWN_DRAW);
      lg_rvalid   <= tag_s2.valid & (tag_s2.owner == OWN_LG);
      if (tag_s2.valid && tag_s2.owner == OWN_DRAW) draw_rdata <= bus.mem_rdata;
      if (tag_s2.valid && tag_s2.owner == OWN_LG)   lg_rdata   <= bus.mem_rdata;

`ifdef BOARD_ARB_STARVE_EN
      if (!bus.lg_req || lg_gnt) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
`endif
    end
  end

  assign bus.draw_gnt    = draw_gnt;
  assign bus.lg_gnt      = lg_gnt;
  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.draw_rvalid = draw_rvalid;
  assign bus.draw_rdata  = draw_rdata;
  assign bus.lg_rvalid   = lg_rvalid;
  assign bus.lg_rdata    = lg_rdata;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a 1-cycle-latency cell RAM model.
// The starvation section follows BOARD_ARB_STARVE_EN like the design.
module tb_board_mem_arbiter;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 4;
  localparam int MAX_WAIT   = 16;
  localparam int STARVE_CYC = 100;

  logic clk = 1'b0;
  logic rst;
  logic vblnk;
  logic ram_load;

  board_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  board_mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .vblnk(vblnk),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [2**ADDR_W];

  function automatic logic [DATA_W-1:0] ram_init(int a);
    case (a)
      1:       return 4'h3;
      2:       return 4'h6;
      3:       return 4'hC;
      4:       return 4'hE;
      5:       return 4'h9;
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 2**ADDR_W; i++) ram[i] <= ram_init(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.draw_req  = 1'b0;
    bus.draw_addr = '0;
    bus.lg_req    = 1'b0;
    bus.lg_we     = 1'b0;
    bus.lg_addr   = '0;
    bus.lg_wdata  = '0;
  endtask

  initial begin
    logic [DATA_W-1:0] exp_tab [4];
    int               lgv;
    int               first;
    logic             dg;
    int               gcnt;
    int               rvc;
    logic [DATA_W-1:0] rvd;

    exp_tab = '{4'h3, 4'h6, 4'hC, 4'hE};
    rst      = 1'b1;
    vblnk    = 1'b0;
    ram_load = 1'b1;
    idle();
    cyc();
    ram_load = 1'b0;

    // Reset state, with requests raised to confirm grants stay low.
    bus.draw_req = 1'b1;
    bus.lg_req   = 1'b1;
    #1;
    check("rst_draw_gnt", bus.draw_gnt, 0);
    check("rst_lg_gnt", bus.lg_gnt, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_draw_rvalid", bus.draw_rvalid, 0);
    check("rst_lg_rvalid", bus.lg_rvalid, 0);
    check("rst_draw_rdata", bus.draw_rdata, 0);
    check("rst_lg_rdata", bus.lg_rdata, 0);
    cyc();
    idle();
    rst = 1'b0;
    cyc();

    // Single draw read of RAM[5].
    bus.draw_req = 1'b1; bus.draw_addr = 9'h005;
    #1;
    check("rd_draw_gnt", bus.draw_gnt, 1);
    check("rd_lg_gnt", bus.lg_gnt, 0);
    cyc();
    idle();
    #1;
    check("rd_n1_mem_en", bus.mem_en, 1);
    check("rd_n1_mem_addr", bus.mem_addr, 9'h005);
    check("rd_n1_mem_we", bus.mem_we, 0);
    check("rd_n1_rvalid", bus.draw_rvalid, 0);
    cyc();
    #1;
    check("rd_n2_mem_en", bus.mem_en, 0);
    check("rd_n2_addr_hold", bus.mem_addr, 9'h005);
    check("rd_n2_rvalid", bus.draw_rvalid, 0);
    cyc();
    #1;
    check("rd_n3_rvalid", bus.draw_rvalid, 1);
    check("rd_n3_rdata", bus.draw_rdata, 4'h9);
    check("rd_n3_lg_rvalid", bus.lg_rvalid, 0);
    cyc();
    #1;
    check("rd_n4_rvalid", bus.draw_rvalid, 0);
    cyc();

    // Conflict in video: draw first, then the logic write.
    bus.draw_req = 1'b1; bus.draw_addr = 9'h007;
    bus.lg_req = 1'b1; bus.lg_we = 1'b1; bus.lg_addr = 9'h010; bus.lg_wdata = 4'hA;
    #1;
    check("vid_draw_gnt", bus.draw_gnt, 1);
    check("vid_lg_gnt", bus.lg_gnt, 0);
    cyc();
    bus.draw_req = 1'b0;
    #1;
    check("vid_lg_gnt2", bus.lg_gnt, 1);
    check("vid_draw_gnt2", bus.draw_gnt, 0);
    cyc();
    idle();
    #1;
    check("wr_mem_en", bus.mem_en, 1);
    check("wr_mem_we", bus.mem_we, 1);
    check("wr_mem_addr", bus.mem_addr, 9'h010);
    check("wr_mem_wdata", bus.mem_wdata, 4'hA);
    lgv = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      lgv += int'(bus.lg_rvalid);
      if (k == 0) check("vid_draw_rvalid", bus.draw_rvalid, 1);
    end
    check("wr_no_lg_rvalid", lgv, 0);
    check("wr_ram_10", ram[9'h010], 4'hA);
    cyc();

    // Blanking: priority flips one cycle after vblnk_q rises.
    vblnk = 1'b1;
    cyc();
    bus.draw_req = 1'b1; bus.draw_addr = 9'h003;
    bus.lg_req = 1'b1; bus.lg_we = 1'b0; bus.lg_addr = 9'h002;
    #1;
    check("blk_lag_draw_gnt", bus.draw_gnt, 1);
    check("blk_lag_lg_gnt", bus.lg_gnt, 0);
    cyc();
    bus.draw_addr = 9'h001;
    #1;
    check("blk_lg_gnt", bus.lg_gnt, 1);
    check("blk_draw_gnt", bus.draw_gnt, 0);
    cyc();
    bus.lg_req = 1'b0;
    #1;
    check("blk_draw_served", bus.draw_gnt, 1);
    cyc();
    idle();
    #1;
    check("blk_r1_draw_rv", bus.draw_rvalid, 1);
    check("blk_r1_draw_rd", bus.draw_rdata, 4'hC);
    check("blk_r1_lg_rv", bus.lg_rvalid, 0);
    cyc();
    #1;
    check("blk_r2_lg_rv", bus.lg_rvalid, 1);
    check("blk_r2_lg_rd", bus.lg_rdata, 4'h6);
    check("blk_r2_draw_rv", bus.draw_rvalid, 0);
    cyc();
    #1;
    check("blk_r3_draw_rv", bus.draw_rvalid, 1);
    check("blk_r3_draw_rd", bus.draw_rdata, 4'h3);
    check("blk_r3_lg_rv", bus.lg_rvalid, 0);
    vblnk = 1'b0;
    cyc();
    cyc();

    // Interleaved reads in video: draw 1, logic 2, draw 3, logic 4.
    for (int k = 0; k < 8; k++) begin
      idle();
      if (k < 4) begin
        bus.draw_req  = (k % 2 == 0);
        bus.lg_req    = (k % 2 == 1);
        bus.draw_addr = 9'(k + 1);
        bus.lg_addr   = 9'(k + 1);
      end
      #1;
      if (k < 4) begin
        check($sformatf("il_draw_gnt%0d", k), bus.draw_gnt, 32'(k % 2 == 0));
        check($sformatf("il_lg_gnt%0d", k), bus.lg_gnt, 32'(k % 2 == 1));
      end
      check($sformatf("il_draw_rv%0d", k), bus.draw_rvalid,
            32'(k >= 3 && k <= 6 && (k - 3) % 2 == 0));
      check($sformatf("il_lg_rv%0d", k), bus.lg_rvalid,
            32'(k >= 3 && k <= 6 && (k - 3) % 2 == 1));
      if (k >= 3 && k <= 6) begin
        if ((k - 3) % 2 == 0) check($sformatf("il_draw_rd%0d", k), bus.draw_rdata, exp_tab[k-3]);
        else                  check($sformatf("il_lg_rd%0d", k), bus.lg_rdata, exp_tab[k-3]);
      end
      cyc();
    end

    // Starvation: draw hogs the RAM during active video.
    first = -1;
    dg    = 1'b1;
    gcnt  = 0;
    for (int k = 0; k < STARVE_CYC; k++) begin
      bus.draw_req = 1'b1; bus.draw_addr = '0;
      bus.lg_req = (first < 0); bus.lg_we = 1'b0; bus.lg_addr = '0;
      #1;
      gcnt += int'(bus.lg_gnt);
      if (first < 0 && bus.lg_gnt) begin
        first = k;
        dg    = bus.draw_gnt;
      end
      cyc();
    end
`ifdef BOARD_ARB_STARVE_EN
    check("starve_first_gnt", first, 17);
    check("starve_draw_gnt", dg, 0);
    check("starve_gnt_count", gcnt, 1);
`else
    check("starve_never_gnt", first, -1);
    check("starve_gnt_count", gcnt, 0);
`endif
    idle();
    for (int k = 0; k < 4; k++) cyc();

    // Reset mid-read from blanking; FSM must restart in video.
    vblnk = 1'b1;
    cyc(); cyc(); cyc();
    bus.draw_req = 1'b1; bus.draw_addr = 9'h005;
    #1;
    check("mr_draw_gnt", bus.draw_gnt, 1);
    cyc();
    rst   = 1'b1;
    vblnk = 1'b0;
    bus.draw_req = 1'b1; bus.lg_req = 1'b1;
    #1;
    check("mr_mem_en", bus.mem_en, 0);
    check("mr_mem_addr", bus.mem_addr, 0);
    check("mr_draw_gnt_rst", bus.draw_gnt, 0);
    check("mr_lg_gnt_rst", bus.lg_gnt, 0);
    check("mr_draw_rvalid", bus.draw_rvalid, 0);
    cyc();
    cyc();
    rst = 1'b0;
    bus.draw_addr = 9'h004; bus.lg_addr = 9'h001;
    #1;
    check("mr_restart_draw_gnt", bus.draw_gnt, 1);
    check("mr_restart_lg_gnt", bus.lg_gnt, 0);
    cyc();
    idle();
    rvc = 0;
    rvd = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (bus.draw_rvalid) begin
        rvc++;
        rvd = bus.draw_rdata;
      end
      cyc();
    end
    check("mr_rvalid_count", rvc, 1);
    check("mr_rvalid_data", rvd, 4'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Shares the single-port board cell-state RAM between two requesters:
  - the board draw path (per-cell reads during scan-out);
  - the game logic (reveal/flag read-modify-write, flood-fill).
- Priority follows the video phase: draw wins during active video, game logic wins during vertical blanking.
- Sits between the top-level board draw path, the game FSM and the cell RAM.

Parameters:
ADDR_W, 9, cell address width (covers up to 512 cells)
DATA_W, 4, cell-state word width
MAX_WAIT, 16, starvation limit in cycles for the logic requester (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
vblnk  in  1  vertical blanking flag from the VGA timing chain
draw_req  in  1  draw read request
draw_addr  in  ADDR_W  draw read address
draw_gnt  out  1  draw request accepted this cycle
draw_rdata  out  DATA_W  draw read data
draw_rvalid  out  1  draw_rdata valid, one-cycle pulse
lg_req  in  1  logic request
lg_we  in  1  logic write (1) / read (0)
lg_addr  in  ADDR_W  logic address
lg_wdata  in  DATA_W  logic write data
lg_gnt  out  1  logic request accepted this cycle
lg_rdata  out  DATA_W  logic read data
lg_rvalid  out  1  lg_rdata valid, one-cycle pulse
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, 1-cycle read latency

Behaviour:
- Reset values: all outputs 0; FSM = S_VIDEO; wait counter 0; pipeline tags cleared.
- Handshake:
  - Requester holds req, addr, we, wdata stable until it sees gnt high.
  - gnt is combinational from the current state and the requests.
  - At most one gnt per cycle; a transfer completes in a cycle with req & gnt.
- Pipeline (grant accepted in cycle N):
  - N+1: mem_en/mem_we/mem_addr/mem_wdata registered; mem_en=1.
  - N+2: RAM drives mem_rdata.
  - N+3: rdata registered to the owning requester, with rvalid pulsed for one cycle.
  - Read latency is 3 cycles. Back-to-back grants give a 1-per-cycle throughput.
- Writes produce no rvalid.
- Each pipeline stage carries a 2-bit tag {valid, owner} so responses route correctly across mixed grants.
- vblnk is registered once (vblnk_q); all mode decisions use vblnk_q.
- FSM states:
  - S_VIDEO: draw has priority; lg_gnt only when draw_req=0. Go to S_BLANK when vblnk_q=1.
  - S_BLANK: logic has priority; draw_gnt only when lg_req=0. Go to S_VIDEO when vblnk_q=0.
  - S_FORCE (optional feature only): one cycle. lg_gnt = lg_req, draw_gnt = 0. Then return to the S_VIDEO/S_BLANK state selected by vblnk_q.
- Simultaneous requests: S_VIDEO grants draw; S_BLANK grants logic; S_FORCE grants logic.
- Idle cycle (no gnt): mem_en=0 next cycle; mem_addr and mem_wdata hold their previous values.
- vblnk toggling while requests are pending: the priority switches on the cycle after vblnk_q changes; in-flight reads still complete.
- Mid-operation reset: the pipeline is flushed, in-flight reads never produce rvalid, and mem_en drops immediately (asynchronous).
- Address and data pass through unmodified; no range checking.

Optional Feature:
- Macro: BOARD_ARB_STARVE_EN
- Enabled:
  - Counter wait_cnt, width $clog2(MAX_WAIT+1), increments each cycle with lg_req=1 and lg_gnt=0. It saturates at MAX_WAIT and clears on any logic grant or when lg_req=0.
  - When wait_cnt==MAX_WAIT in S_VIDEO, the next state is S_FORCE.
  - The guaranteed worst-case logic wait is MAX_WAIT+1 cycles.
- Disabled: no counter and no S_FORCE state; pure phase priority (logic may starve for a full active frame).

Test Plan:
- Single read: S_VIDEO, draw_req with draw_addr=0x05, RAM[5]=0x9 → draw_gnt same cycle, mem_en=1/mem_addr=0x05 at N+1, draw_rvalid=1 with draw_rdata=0x9 at N+3, for exactly one cycle.
- Conflict in video: both req in S_VIDEO → draw_gnt=1, lg_gnt=0. Draw drops req → lg_gnt next cycle. Write of lg_wdata=0xA to 0x10 → RAM[0x10]=0xA, no lg_rvalid.
- Conflict in blanking: vblnk=1 for 2 cycles, both req → lg_gnt=1, draw_gnt=0 from the cycle after vblnk_q rises; draw is served once lg_req=0.
- Interleaved reads: alternating draw and logic grants to addresses 1,2,3,4 → each rvalid goes to the correct requester with the matching data; never both rvalid in the same cycle.
- Starvation (BOARD_ARB_STARVE_EN, MAX_WAIT=16): draw_req held high, lg_req high in S_VIDEO → lg_gnt on cycle 17, draw_gnt=0 that cycle. Without the macro → lg_gnt stays 0 for 100 cycles.
- Reset mid-read: assert rst at N+1 after a draw grant → all outputs 0 immediately; no draw_rvalid after rst deasserts; the FSM restarts in S_VIDEO.
